// File: rtl/tsb_arb_pkg.sv
// ----------------------------------------------------------------------------
// tsb_arb_pkg
// Shared definitions for the tristate bus arbiter:
//   - tsb_state_e : arbiter FSM states
//   - width localparams for the largest supported configuration (N <= 16)
//   - onehot_encode / onehot_decode helpers. They work on the widest vector,
//     and callers zero-extend or truncate to their own N with size casts.
// ----------------------------------------------------------------------------
package tsb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2,
        PARK  = 2'd3
    } tsb_state_e;

    localparam int TSB_MAX_N    = 16;
    localparam int TSB_MAX_ID_W = $clog2(TSB_MAX_N);

    // Index -> one-hot vector.
    function automatic logic [TSB_MAX_N-1:0] onehot_encode(input logic [TSB_MAX_ID_W-1:0] idx);
        logic [TSB_MAX_N-1:0] vec;
        vec      = {TSB_MAX_N{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // One-hot vector -> index; an all-zero vector decodes to 0.
    function automatic logic [TSB_MAX_ID_W-1:0] onehot_decode(input logic [TSB_MAX_N-1:0] vec);
        logic [TSB_MAX_ID_W-1:0] idx;
        idx = {TSB_MAX_ID_W{1'b0}};
        for (int i = 0; i < TSB_MAX_N; i++) begin
            if (vec[i]) begin
                idx = TSB_MAX_ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Starting just above rr_ptr and wrapping
// modulo N, returns the first requester whose req bit is set.
// Ports:
//   req    [N-1:0]          request vector
//   rr_ptr [$clog2(N)-1:0]  last owner; it gets the lowest priority
//   winner [$clog2(N)-1:0]  selected index (0 when nothing is found)
//   found                   high when any req bit is set
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [$clog2(N)-1:0] winner,
    output logic                 found
);

    localparam int ID_W = $clog2(N);
    // One extra bit so that rr_ptr + k (at most 2N-1) cannot overflow.
    localparam logic [ID_W:0] N_W = (ID_W + 1)'(N);

    logic [ID_W:0] sum_s;
    logic [ID_W:0] idx_s;

    // First set request above rr_ptr, scanning with a wrap at N (N need not be a power of two).
    always_comb begin
        winner = {ID_W{1'b0}};
        found  = 1'b0;
        sum_s  = {(ID_W + 1){1'b0}};
        idx_s  = {(ID_W + 1){1'b0}};
        for (int k = 1; k <= N; k++) begin
            sum_s = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (sum_s >= N_W) begin
                idx_s = sum_s - N_W;
            end else begin
                idx_s = sum_s;
            end
            if (!found && req[idx_s[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx_s[ID_W-1:0];
            end else begin
                found  = found;
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tristate_bus_arbiter
// Round-robin arbiter that shares one tristate bus among N requesters. It
// produces registered one-hot drive enables and enforces break-before-make:
// after any owner change the bus is left undriven for DEAD_CYCLES turnaround
// cycles, followed by one IDLE cycle in which the next winner is picked.
//
// Parameters:
//   N           number of requesters (2..16)
//   MAX_HOLD    grant cycles after which an owner is revoked if others wait
//   DEAD_CYCLES all-off turnaround cycles between owners
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester level request
//   drv_en     one-hot-or-zero tristate enables (registered)
//   gnt_valid  |drv_en (registered)
//   gnt_id     owner index, 0 when gnt_valid is low (registered)
//   turn       high during turnaround (registered)
//
// Build option: define TSB_ARB_PARK_EN so that an owner releasing with no other
// request pending is parked (its driver stays enabled and holds the bus at a
// defined level) instead of tristating the bus.
// ----------------------------------------------------------------------------
module tristate_bus_arbiter #(
    parameter int N           = 4,
    parameter int MAX_HOLD    = 8,
    parameter int DEAD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         drv_en,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 turn
);

    import tsb_arb_pkg::*;

    localparam int ID_W   = $clog2(N);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(N - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO  = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(MAX_HOLD);
    localparam logic [DEAD_W-1:0] DEAD_ZERO  = DEAD_W'(0);
    localparam logic [DEAD_W-1:0] DEAD_ONE   = DEAD_W'(1);
    localparam logic [DEAD_W-1:0] DEAD_LAST  = DEAD_W'(DEAD_CYCLES - 1);

    tsb_state_e        state_r,    state_s;
    logic [ID_W-1:0]   owner_r,    owner_s;
    logic [ID_W-1:0]   rr_ptr_r,   rr_ptr_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [DEAD_W-1:0] dead_cnt_r, dead_cnt_s;
    logic [N-1:0]      drv_en_s;
    logic              turn_s;
    logic [ID_W-1:0]   gnt_id_s;

    logic [ID_W-1:0]   winner_s;
    logic              found_s;
    logic [N-1:0]      owner_mask_s;
    logic [N-1:0]      winner_mask_s;
    logic              owner_req_s;
    logic              others_s;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .winner (winner_s),
        .found  (found_s)
    );

    // Masks of the current owner and the picker's winner; who else is waiting.
    always_comb begin
        owner_mask_s  = N'(onehot_encode(TSB_MAX_ID_W'(owner_r)));
        winner_mask_s = N'(onehot_encode(TSB_MAX_ID_W'(winner_s)));
        owner_req_s   = |(req & owner_mask_s);
        others_s      = |(req & ~owner_mask_s);
    end

    // Next-state logic; drv_en_s/turn_s describe the cycle after the next edge.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        rr_ptr_s   = rr_ptr_r;
        hold_cnt_s = hold_cnt_r;
        dead_cnt_s = dead_cnt_r;
        drv_en_s   = {N{1'b0}};
        turn_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s    = GRANT;
                    owner_s    = winner_s;
                    hold_cnt_s = HOLD_ZERO;
                    drv_en_s   = winner_mask_s;
                end else begin
                    state_s    = IDLE;
                end
            end

            GRANT: begin
                if (!owner_req_s) begin
                    rr_ptr_s   = owner_r;
                    hold_cnt_s = HOLD_ZERO;
`ifdef TSB_ARB_PARK_EN
                    if (!others_s) begin
                        state_s  = PARK;
                        drv_en_s = owner_mask_s;
                    end else begin
                        state_s  = TURN;
                        turn_s   = 1'b1;
                    end
`else
                    state_s    = TURN;
                    turn_s     = 1'b1;
`endif
                end else if (others_s && (hold_cnt_r >= HOLD_LIMIT)) begin
                    // ">=" also revokes at once when the counter already saturated
                    // while this owner was alone on the bus.
                    state_s    = TURN;
                    turn_s     = 1'b1;
                    rr_ptr_s   = owner_r;
                    hold_cnt_s = HOLD_ZERO;
                end else begin
                    drv_en_s   = owner_mask_s;
                    if (hold_cnt_r != HOLD_SAT) begin
                        hold_cnt_s = hold_cnt_r + HOLD_ONE;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end

            TURN: begin
                if (dead_cnt_r == DEAD_LAST) begin
                    state_s    = IDLE;
                    dead_cnt_s = DEAD_ZERO;
                end else begin
                    state_s    = TURN;
                    dead_cnt_s = dead_cnt_r + DEAD_ONE;
                    turn_s     = 1'b1;
                end
            end

            PARK: begin
`ifdef TSB_ARB_PARK_EN
                // Someone else wins over the parked owner re-requesting.
                if (others_s) begin
                    state_s    = TURN;
                    turn_s     = 1'b1;
                end else if (owner_req_s) begin
                    state_s    = GRANT;
                    hold_cnt_s = HOLD_ZERO;
                    drv_en_s   = owner_mask_s;
                end else begin
                    state_s    = PARK;
                    drv_en_s   = owner_mask_s;
                end
`else
                state_s = IDLE;
`endif
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Grant index taken from the enables that get registered at this edge.
    always_comb begin
        gnt_id_s = ID_W'(onehot_decode(TSB_MAX_N'(drv_en_s)));
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            owner_r    <= {ID_W{1'b0}};
            rr_ptr_r   <= LAST_ID;
            hold_cnt_r <= HOLD_ZERO;
            dead_cnt_r <= DEAD_ZERO;
            drv_en     <= {N{1'b0}};
            gnt_valid  <= 1'b0;
            gnt_id     <= {ID_W{1'b0}};
            turn       <= 1'b0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            rr_ptr_r   <= rr_ptr_s;
            hold_cnt_r <= hold_cnt_s;
            dead_cnt_r <= dead_cnt_s;
            drv_en     <= drv_en_s;
            gnt_valid  <= |drv_en_s;
            gnt_id     <= gnt_id_s;
            turn       <= turn_s;
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tristate_bus_arbiter
// Self-checking bench for tristate_bus_arbiter (N=4, MAX_HOLD=4,
// DEAD_CYCLES=1). A reference model tracks owner, tenure length, remaining
// cool-down cycles and the last owner, and predicts the outputs seen after
// every clock edge. Every cycle also checks one-hot drive and the gap between
// two different owners. Honours TSB_ARB_PARK_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_tristate_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int DEAD     = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] drv_en;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         turn;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_owner;    // -1 when nobody owns (or parks on) the bus
    int m_tenure;   // cycles owned so far in the current tenure
    int m_cool;     // bus-off cycles still flagged as turnaround
    int m_last;     // previous owner (lowest priority next time)
    bit m_parked;

    logic [N-1:0] exp_drv;
    logic         exp_valid;
    logic [1:0]   exp_id;
    logic         exp_turn;

    int gap_owner;
    int gap_zeros;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(
        .N           (N),
        .MAX_HOLD    (MAX_HOLD),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .drv_en    (drv_en),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .turn      (turn)
    );

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] own_mask;
        logic [N-1:0] others;
        int           i;
        own_mask = 4'b0000;
        if (m_owner >= 0) own_mask = 4'b0001 << m_owner;
        others = r & ~own_mask;
        if (rs) begin
            m_owner = -1; m_tenure = 0; m_cool = 0; m_last = N - 1; m_parked = 0;
        end else if (m_parked) begin
            if (others != 4'b0000) begin
                m_parked = 0; m_owner = -1; m_cool = DEAD;
            end else if ((r & own_mask) != 4'b0000) begin
                m_parked = 0; m_tenure = 0;
            end
        end else if (m_owner >= 0) begin
            if ((r & own_mask) == 4'b0000) begin
                m_last = m_owner;
`ifdef TSB_ARB_PARK_EN
                if (others == 4'b0000) m_parked = 1;
                else begin m_owner = -1; m_cool = DEAD; end
`else
                m_owner = -1; m_cool = DEAD;
`endif
            end else if (others != 4'b0000 && m_tenure >= MAX_HOLD - 1) begin
                m_last = m_owner; m_owner = -1; m_cool = DEAD;
            end else begin
                m_tenure++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                i = (m_last + k) % N;
                if (m_owner < 0 && r[i[1:0]]) begin
                    m_owner = i; m_tenure = 0;
                end
            end
        end
        exp_valid = (m_owner >= 0);
        exp_drv   = exp_valid ? (4'b0001 << m_owner) : 4'b0000;
        exp_id    = exp_valid ? m_owner[1:0] : 2'd0;
        exp_turn  = !exp_valid && (m_cool > 0);
    endtask

    // One clock: drive, advance the model, then watch invariants after the edge.
    task automatic tick(input logic [N-1:0] r, input logic rs);
        int id;
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        total++;
        if (!$onehot0(drv_en)) begin
            bad++;
            $display("FAIL onehot0 drv_en=%b required one-hot or zero", drv_en);
        end
        if (rs) begin
            gap_owner = -1; gap_zeros = 0;
        end else if (drv_en == 4'b0000) begin
            gap_zeros++;
        end else begin
            id = 0;
            for (int b = 0; b < N; b++) if (drv_en[b[1:0]]) id = b;
            if (gap_owner >= 0 && id != gap_owner) begin
                total++;
                if (gap_zeros < DEAD + 1) begin
                    bad++;
                    $display("FAIL gap %0d->%0d zero_cycles=%0d required>=%0d", gap_owner, id, gap_zeros, DEAD + 1);
                end
            end
            gap_owner = id; gap_zeros = 0;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            tick(4'b1111, 1'b1);
            total++;
            if ({drv_en, gnt_valid, gnt_id, turn} !== 8'b0000_0_00_0) begin
                bad++;
                $display("FAIL reset c=%0d got drv=%b v=%b id=%0d turn=%b required all zero", c, drv_en, gnt_valid, gnt_id, turn);
            end
        end
        tick(4'b1111, 1'b0);
        total++;
        if (drv_en !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_grant got drv=%b id=%0d v=%b required drv=0001 id=0 v=1", drv_en, gnt_id, gnt_valid);
        end
    endtask

    task automatic test_single();
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b0);
        tick(4'b0100, 1'b0);
        total++;
        if (drv_en !== 4'b0100 || gnt_id !== 2'd2) begin
            bad++;
            $display("FAIL single_latency got drv=%b id=%0d required drv=0100 id=2", drv_en, gnt_id);
        end
        for (int c = 0; c < 8; c++) begin
            tick((c < 3) ? 4'b0100 : 4'b0000, 1'b0);
            total++;
            if ({drv_en, gnt_valid, gnt_id, turn} !== {exp_drv, exp_valid, exp_id, exp_turn}) begin
                bad++;
                $display("FAIL single c=%0d got drv=%b v=%b id=%0d turn=%b required drv=%b v=%b id=%0d turn=%b",
                         c, drv_en, gnt_valid, gnt_id, turn, exp_drv, exp_valid, exp_id, exp_turn);
            end
        end
    endtask

    task automatic test_round_robin();
        tick(4'b0000, 1'b1);
        for (int c = 0; c < 32; c++) begin
            tick(4'b1111, 1'b0);
            total++;
            if ({drv_en, gnt_valid, gnt_id, turn} !== {exp_drv, exp_valid, exp_id, exp_turn}) begin
                bad++;
                $display("FAIL round_robin c=%0d got drv=%b v=%b id=%0d turn=%b required drv=%b v=%b id=%0d turn=%b",
                         c, drv_en, gnt_valid, gnt_id, turn, exp_drv, exp_valid, exp_id, exp_turn);
            end
        end
    endtask

    task automatic test_lone_hold();
        tick(4'b0000, 1'b1);
        for (int c = 0; c < 28; c++) begin
            tick((c < 20) ? 4'b0001 : 4'b1001, 1'b0);
            total++;
            if ({drv_en, gnt_valid, gnt_id, turn} !== {exp_drv, exp_valid, exp_id, exp_turn}) begin
                bad++;
                $display("FAIL lone_hold c=%0d got drv=%b v=%b id=%0d turn=%b required drv=%b v=%b id=%0d turn=%b",
                         c, drv_en, gnt_valid, gnt_id, turn, exp_drv, exp_valid, exp_id, exp_turn);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        tick(4'b0000, 1'b1);
        tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b0);
        tick(4'b1111, 1'b1);
        total++;
        if (drv_en !== 4'b0000 || gnt_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_grant got drv=%b v=%b required drv=0000 v=0", drv_en, gnt_valid);
        end
        tick(4'b1111, 1'b0);
        total++;
        if (drv_en !== 4'b0001 || {drv_en, gnt_valid, gnt_id, turn} !== {exp_drv, exp_valid, exp_id, exp_turn}) begin
            bad++;
            $display("FAIL reset_mid_grant_next got drv=%b id=%0d required drv=0001 id=0", drv_en, gnt_id);
        end
    endtask

`ifdef TSB_ARB_PARK_EN
    task automatic test_park();
        tick(4'b0000, 1'b1);
        tick(4'b0010, 1'b0);
        for (int c = 0; c < 7; c++) begin
            tick((c == 2 || c == 3) ? 4'b0000 : 4'b0010, 1'b0);
            total++;
            if (drv_en !== 4'b0010 || gnt_valid !== 1'b1) begin
                bad++;
                $display("FAIL park_hold c=%0d got drv=%b v=%b required drv=0010 v=1", c, drv_en, gnt_valid);
            end
        end
        for (int c = 0; c < 5; c++) begin
            tick((c == 0) ? 4'b0000 : 4'b1000, 1'b0);
            total++;
            if ({drv_en, gnt_valid, gnt_id, turn} !== {exp_drv, exp_valid, exp_id, exp_turn}) begin
                bad++;
                $display("FAIL park_switch c=%0d got drv=%b v=%b id=%0d turn=%b required drv=%b v=%b id=%0d turn=%b",
                         c, drv_en, gnt_valid, gnt_id, turn, exp_drv, exp_valid, exp_id, exp_turn);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] r;
        logic         rs;
        r = 4'b0000;
        tick(4'b0000, 1'b1);
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 6) == 0) r[b] = ~r[b];
            end
            rs = ($urandom_range(0, 120) == 0);
            tick(r, rs);
            total++;
            if ({drv_en, gnt_valid, gnt_id, turn} !== {exp_drv, exp_valid, exp_id, exp_turn}) begin
                bad++;
                $display("FAIL random c=%0d req=%b got drv=%b v=%b id=%0d turn=%b required drv=%b v=%b id=%0d turn=%b",
                         c, r, drv_en, gnt_valid, gnt_id, turn, exp_drv, exp_valid, exp_id, exp_turn);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        m_owner   = -1;
        m_tenure  = 0;
        m_cool    = 0;
        m_last    = N - 1;
        m_parked  = 0;
        gap_owner = -1;
        gap_zeros = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_lone_hold();
        test_reset_mid_grant();
`ifdef TSB_ARB_PARK_EN
        test_park();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
